// File: rtl/div_ctrl.sv
// Runtime clock-enable divider controller: holds the active ratio, takes new ratios
// over valid/ready and applies them only at period boundaries.
module div_ctrl #(
  parameter int unsigned W           = 27,
  parameter int unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick,
  output logic         clk_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);
  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         tick_d, err_d, clk_d, busy_d, ready_d;
  logic         xfer, cfg_ok, term;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DEF_DIV;
      pend_q    <= '0;
      tick      <= 1'b0;
      clk_out   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      tick      <= tick_d;
      clk_out   <= clk_d;
      cfg_err   <= err_d;
      cfg_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    xfer    = cfg_valid && cfg_ready;
    cfg_ok  = (cfg_div >= TWO);
    err_d   = xfer && !cfg_ok;
    term    = (cnt_q == div_q - ONE);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && cfg_ok) div_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (xfer && cfg_ok) div_d = cfg_div;
        end else begin
          // Wrap uses the old ratio even when a new one arrives on terminal count.
          if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
          if (xfer && cfg_ok) begin
            pend_d  = cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          div_d   = pend_q;
        end else if (term) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = pend_q;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so the registered copies line up with cnt.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d != PEND);
    clk_d   = (state_d != IDLE) && (cnt_d >= (div_d >> 1));
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against a period/position reference model.
module tb_div_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned DEF = 4;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready, cfg_err, tick, clk_out, busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model: running flag, position within the period, ratio, pending ratio
  bit          m_running;
  bit          m_pending;
  int unsigned m_pos, m_ratio, m_pend;
  bit          m_tick, m_clk, m_err, m_ready, m_busy;

  div_ctrl #(.W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .clk_out  (clk_out),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_pending = 0; m_pos = 0; m_ratio = DEF; m_pend = 0;
    m_tick = 0; m_clk = 0; m_err = 0; m_ready = 1; m_busy = 0;
  endtask

  task automatic model_edge();
    bit accept, good, was_pending;
    int unsigned req;
    req         = int'(cfg_div);
    accept      = cfg_valid && m_ready;
    good        = accept && (req >= 2);
    m_err       = accept && !good;
    m_tick      = 0;
    was_pending = m_pending;
    if (!m_running) begin
      if (good) m_ratio = req;
      if (en) begin m_running = 1; m_pos = 0; end
    end else if (!en) begin
      if (m_pending) begin m_ratio = m_pend; m_pending = 0; end
      else if (good) m_ratio = req;
      m_running = 0;
      m_pos = 0;
    end else begin
      if (m_pos == m_ratio - 1) begin
        m_pos = 0;
        m_tick = 1;
        if (m_pending) begin m_ratio = m_pend; m_pending = 0; end
      end else begin
        m_pos++;
      end
      if (good && !was_pending) begin m_pend = req; m_pending = 1; end
    end
    m_clk   = m_running && (m_pos >= m_ratio / 2);
    m_busy  = m_running;
    m_ready = !m_pending;
  endtask

  task automatic compare_all();
    check("tick", 32'(tick), 32'(m_tick));
    check("clk_out", 32'(clk_out), 32'(m_clk));
    check("busy", 32'(busy), 32'(m_busy));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic random_run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      en        = ($urandom_range(0, 99) < 95);
      cfg_valid = ($urandom_range(0, 99) < 12);
      cfg_div   = W'($urandom_range(0, 12));
      step();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    int unsigned guard;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #23;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;

    // default ratio free-running
    en = 1'b1;
    for (int unsigned i = 0; i < 13; i++) step();

    // invalid ratio while running
    cfg_valid = 1'b1; cfg_div = W'(1);
    step();
    cfg_valid = 1'b0;
    for (int unsigned i = 0; i < 6; i++) step();

    // new ratio, then stop mid-period and restart
    cfg_valid = 1'b1; cfg_div = W'(5);
    step();
    cfg_valid = 1'b0;
    for (int unsigned i = 0; i < 12; i++) step();
    en = 1'b0; step(); step();
    en = 1'b1;
    for (int unsigned i = 0; i < 12; i++) step();

    random_run(3000);

    // enter PEND, then reset asynchronously between edges
    en = 1'b1;
    step(); step();
    cfg_valid = 1'b1; cfg_div = W'(9);
    guard = 0;
    while (!m_pending && guard < 20) begin
      step();
      guard++;
    end
    cfg_valid = 1'b0;
    check("pend_entered", 32'(cfg_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_tick", 32'(tick), 32'd0);
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_cfg_ready", 32'(cfg_ready), 32'd1);
    check("async_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 14; i++) step();

    random_run(1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
